// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: width defaults,
// the zero-register constant, the queued entry layout {tag, rw, data} and the age test.
package regfile_wb_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_SEQ_W  = 3;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  function automatic int rw_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int tag_lsb(input int data_w, input int addr_w);
    return data_w + addr_w;
  endfunction

  function automatic int entry_w(input int data_w, input int addr_w, input int seq_w);
    return data_w + addr_w + seq_w;
  endfunction

  // diff = tag_other - tag_this (mod 2^SEQ_W); at most 2*depth+1 tags are ever live
  function automatic logic is_older(input int diff, input int depth);
    return (diff >= 1) && (diff <= 2 * depth);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small register-based FIFO for one writeback requester. Exposes per-slot valid
// bits and a key field per slot so the parent can build its pending-write mask.
module wb_fifo #(
  parameter int DEPTH   = 2,
  parameter int WIDTH   = 40,
  parameter int KEY_LSB = 32,
  parameter int KEY_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ready,
  output logic [DEPTH-1:0]         slot_valid,
  output logic [DEPTH*KEY_W-1:0]   slot_key
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic             ready_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign count_next = count_reg + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);

  always_comb begin
    valid_next = valid_reg;
    if (push_ok) valid_next[wr_ptr_reg] = 1'b1;
    if (pop_ok)  valid_next[rd_ptr_reg] = 1'b0;
  end

  // Ready is registered from the next count, so a full FIFO stays not-ready
  // even in a cycle where it pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      valid_reg <= valid_next;
      ready_reg <= (count_next < (PTR_W + 1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= din;
  end

  assign head       = mem_reg[rd_ptr_reg];
  assign count      = count_reg;
  assign ready      = ready_reg;
  assign slot_valid = valid_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_key
    assign slot_key[gi*KEY_W +: KEY_W] = mem_reg[gi][KEY_LSB +: KEY_W];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU (A) and load (B) writeback queues.
// Optional REGFILE_WB_PERF_EN adds a saturating head-conflict counter.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 2,
  parameter int SEQ_W      = DEF_SEQ_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rw,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rw,
  input  logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] rf_pw,
  output logic [ADDR_W-1:0] rf_rw,
  output logic              rf_le,
  output logic [31:0]       pending_mask,
  output logic              busy
`ifdef REGFILE_WB_PERF_EN
  ,
  output logic [15:0]       perf_conflicts
`endif
);

  localparam int ENTRY_W = entry_w(DATA_W, ADDR_W, SEQ_W);
  localparam int RW_LSB  = rw_lsb(DATA_W);
  localparam int TAG_LSB = tag_lsb(DATA_W, ADDR_W);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RW_ZERO = ADDR_W'(REG_ZERO);

  logic [SEQ_W-1:0]          seq_reg;
  logic [SEQ_W-1:0]          a_tag;
  logic [SEQ_W-1:0]          b_tag;
  logic                      a_push;
  logic                      b_push;
  logic [ENTRY_W-1:0]        a_head;
  logic [ENTRY_W-1:0]        b_head;
  logic [CNT_W-1:0]          a_count;
  logic [CNT_W-1:0]          b_count;
  logic                      a_full;
  logic                      b_full;
  logic                      a_empty;
  logic                      b_empty;
  logic [FIFO_DEPTH-1:0]     a_slot_valid;
  logic [FIFO_DEPTH-1:0]     b_slot_valid;
  logic [FIFO_DEPTH*ADDR_W-1:0] a_slot_key;
  logic [FIFO_DEPTH*ADDR_W-1:0] b_slot_key;
  logic [ADDR_W-1:0]         a_slot_rw [FIFO_DEPTH];
  logic [ADDR_W-1:0]         b_slot_rw [FIFO_DEPTH];

  logic                      grant_a;
  logic                      grant_b;
  req_e                      rr_last_reg;
  logic [ADDR_W-1:0]         a_h_rw;
  logic [ADDR_W-1:0]         b_h_rw;
  logic [SEQ_W-1:0]          a_h_tag;
  logic [SEQ_W-1:0]          b_h_tag;
  logic [SEQ_W-1:0]          a_age_diff;
  logic [DATA_W-1:0]         g_data;
  logic [ADDR_W-1:0]         g_rw;
  logic                      g_write;

  logic [DATA_W-1:0]         rf_pw_reg;
  logic [ADDR_W-1:0]         rf_rw_reg;
  logic                      rf_le_reg;
  logic [31:0]               pending_bits;

  // A is older than B when both push on the same edge.
  assign a_push = a_valid & a_ready & ~a_full;
  assign b_push = b_valid & b_ready & ~b_full;
  assign a_tag  = seq_reg;
  assign b_tag  = seq_reg + SEQ_W'(a_push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_reg <= '0;
    else        seq_reg <= seq_reg + SEQ_W'(a_push) + SEQ_W'(b_push);
  end

  wb_fifo #(
    .DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W), .KEY_LSB(RW_LSB), .KEY_W(ADDR_W)
  ) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .push(a_push), .din({a_tag, a_rw, a_data}),
    .pop(grant_a), .head(a_head), .count(a_count), .full(a_full),
    .empty(a_empty), .ready(a_ready), .slot_valid(a_slot_valid),
    .slot_key(a_slot_key)
  );

  wb_fifo #(
    .DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W), .KEY_LSB(RW_LSB), .KEY_W(ADDR_W)
  ) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .push(b_push), .din({b_tag, b_rw, b_data}),
    .pop(grant_b), .head(b_head), .count(b_count), .full(b_full),
    .empty(b_empty), .ready(b_ready), .slot_valid(b_slot_valid),
    .slot_key(b_slot_key)
  );

  assign a_h_rw     = a_head[RW_LSB +: ADDR_W];
  assign b_h_rw     = b_head[RW_LSB +: ADDR_W];
  assign a_h_tag    = a_head[TAG_LSB +: SEQ_W];
  assign b_h_tag    = b_head[TAG_LSB +: SEQ_W];
  assign a_age_diff = b_h_tag - a_h_tag;

  // Same destination must retire in tag order; otherwise plain round-robin.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!a_empty && b_empty) begin
      grant_a = 1'b1;
    end else if (a_empty && !b_empty) begin
      grant_b = 1'b1;
    end else if (!a_empty && !b_empty) begin
      if ((a_h_rw == b_h_rw) && (a_h_rw != RW_ZERO)) begin
        if (is_older(int'(a_age_diff), FIFO_DEPTH)) grant_a = 1'b1;
        else                                        grant_b = 1'b1;
      end else if (rr_last_reg == REQ_B) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
    end
  end

  assign g_data  = grant_a ? a_head[DATA_W-1:0] : b_head[DATA_W-1:0];
  assign g_rw    = grant_a ? a_h_rw : b_h_rw;
  assign g_write = (grant_a | grant_b) && (g_rw != RW_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_reg <= REQ_B;
      rf_pw_reg   <= '0;
      rf_rw_reg   <= '0;
      rf_le_reg   <= 1'b0;
    end else begin
      if (grant_a)      rr_last_reg <= REQ_A;
      else if (grant_b) rr_last_reg <= REQ_B;
      rf_le_reg <= g_write;
      // Register-zero entries consume their slot but leave the port untouched.
      if (g_write) begin
        rf_pw_reg <= g_data;
        rf_rw_reg <= g_rw;
      end
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    assign a_slot_rw[gi] = a_slot_key[gi*ADDR_W +: ADDR_W];
    assign b_slot_rw[gi] = b_slot_key[gi*ADDR_W +: ADDR_W];
  end

  always_comb begin
    pending_bits = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (a_slot_valid[i]) pending_bits[a_slot_rw[i]] = 1'b1;
      if (b_slot_valid[i]) pending_bits[b_slot_rw[i]] = 1'b1;
    end
    if (rf_le_reg) pending_bits[rf_rw_reg] = 1'b1;
    pending_bits[REG_ZERO] = 1'b0;
  end

  assign rf_pw        = rf_pw_reg;
  assign rf_rw        = rf_rw_reg;
  assign rf_le        = rf_le_reg;
  assign pending_mask = pending_bits;
  assign busy         = (a_count != '0) | (b_count != '0) | rf_le_reg;

`ifdef REGFILE_WB_PERF_EN
  logic [15:0] perf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_reg <= '0;
    end else if (!a_empty && !b_empty && (perf_reg != 16'hFFFF)) begin
      perf_reg <= perf_reg + 16'd1;
    end
  end

  assign perf_conflicts = perf_reg;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: expected writes are queued when stimulus
// is driven and a negedge monitor pops and compares every rf_le pulse.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rw, b_rw;
  logic [31:0] a_data, b_data;
  logic [31:0] rf_pw;
  logic [4:0]  rf_rw;
  logic        rf_le;
  logic [31:0] pending_mask;
  logic        busy;
`ifdef REGFILE_WB_PERF_EN
  logic [15:0] perf_conflicts;
`endif

  typedef struct packed {
    logic [4:0]  rw;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_exp;
  int  checks = 0;
  int  errors = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rw(a_rw), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rw(b_rw), .b_data(b_data),
    .rf_pw(rf_pw), .rf_rw(rf_rw), .rf_le(rf_le),
    .pending_mask(pending_mask), .busy(busy)
`ifdef REGFILE_WB_PERF_EN
    , .perf_conflicts(perf_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && rf_le) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got write r%0d=%h, required no write", rf_rw, rf_pw);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rf_rw !== mon_exp.rw || rf_pw !== mon_exp.data) begin
          errors++;
          $display("FAIL wb_order: got r%0d=%h, required r%0d=%h",
                   rf_rw, rf_pw, mon_exp.rw, mon_exp.data);
        end else begin
          $display("write r%0d = %h", rf_rw, rf_pw);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    to_edge();
  endtask

  // Offers one A/B beat for exactly one edge; reports which were accepted.
  task automatic step(input bit av, input logic [4:0] arw, input logic [31:0] ad,
                      input bit bv, input logic [4:0] brw, input logic [31:0] bd,
                      output bit a_acc, output bit b_acc);
    a_valid = av; a_rw = arw; a_data = ad;
    b_valid = bv; b_rw = brw; b_data = bd;
    @(negedge clk);
    a_acc = av && a_ready;
    b_acc = bv && b_ready;
    to_edge();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_rw = 5'd5; a_data = 32'h1111_2222; b_rw = 5'd6; b_data = 32'h3333_4444;
    repeat (2) @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got a=%b b=%b, required 0 0", a_ready, b_ready);
    end
    checks++;
    if (rf_le !== 1'b0 || pending_mask !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got le=%b mask=%h busy=%b, required 0 0 0",
               rf_le, pending_mask, busy);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    to_edge();
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got a=%b b=%b, required 1 1", a_ready, b_ready);
    end
    checks++;
    if (rf_le !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: got le=%b busy=%b, required 0 0", rf_le, busy);
    end
    to_edge();
  endtask

  task automatic test_single_write();
    bit aa, ba;
    exp_q.push_back('{rw: 5'd5, data: 32'hDEADBEEF});
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, aa, ba);
    checks++;
    if (aa !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: got %b, required 1", aa);
    end
    @(negedge clk);
    checks++;
    if (pending_mask !== 32'h20 || rf_le !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_queued: got mask=%h le=%b busy=%b, required 00000020 0 1",
               pending_mask, rf_le, busy);
    end
    to_edge();
    @(negedge clk);
    checks++;
    if (rf_le !== 1'b1 || rf_rw !== 5'd5 || rf_pw !== 32'hDEADBEEF || pending_mask !== 32'h20) begin
      errors++;
      $display("FAIL single_output: got le=%b rw=%0d pw=%h mask=%h, required 1 5 deadbeef 00000020",
               rf_le, rf_rw, rf_pw, pending_mask);
    end
    @(negedge clk);
    checks++;
    if (rf_le !== 1'b0 || pending_mask !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got le=%b mask=%h busy=%b, required 0 0 0",
               rf_le, pending_mask, busy);
    end
    checks++;
    if (rf_rw !== 5'd5 || rf_pw !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_hold: got rw=%0d pw=%h, required 5 deadbeef", rf_rw, rf_pw);
    end
    to_edge();
  endtask

  task automatic test_round_robin();
    bit aa1, ba1, aa2, ba2;
    do_reset();
    exp_q.push_back('{rw: 5'd1, data: 32'hA000_0001});
    exp_q.push_back('{rw: 5'd3, data: 32'hB000_0003});
    exp_q.push_back('{rw: 5'd2, data: 32'hA000_0002});
    exp_q.push_back('{rw: 5'd4, data: 32'hB000_0004});
    step(1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd3, 32'hB000_0003, aa1, ba1);
    step(1'b1, 5'd2, 32'hA000_0002, 1'b1, 5'd4, 32'hB000_0004, aa2, ba2);
    checks++;
    if ({aa1, ba1, aa2, ba2} !== 4'b1111) begin
      errors++;
      $display("FAIL rr_accept: got %b, required 1111", {aa1, ba1, aa2, ba2});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rf_le !== (i < 4)) begin
        errors++;
        $display("FAIL rr_le_cycle%0d: got %b, required %b", i, rf_le, (i < 4));
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    to_edge();
  endtask

  task automatic test_age_override();
    bit aa1, ba1, aa2, ba2, aa3, ba3;
    do_reset();
    exp_q.push_back('{rw: 5'd10, data: 32'h0000_00AA});
    exp_q.push_back('{rw: 5'd11, data: 32'h0000_00BB});
    exp_q.push_back('{rw: 5'd7,  data: 32'h0000_0001});
    exp_q.push_back('{rw: 5'd7,  data: 32'h0000_0002});
    step(1'b1, 5'd10, 32'h0000_00AA, 1'b1, 5'd11, 32'h0000_00BB, aa1, ba1);
    step(1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'h0000_0001, aa2, ba2);
    step(1'b1, 5'd7,  32'h0000_0002, 1'b0, 5'd0,  32'h0,         aa3, ba3);
    checks++;
    if ({aa1, ba1, ba2, aa3} !== 4'b1111) begin
      errors++;
      $display("FAIL age_accept: got %b, required 1111", {aa1, ba1, ba2, aa3});
    end
    @(negedge clk);
    checks++;
    if (pending_mask !== 32'h0000_0880 || rf_le !== 1'b1 || rf_rw !== 5'd11) begin
      errors++;
      $display("FAIL age_mask: got mask=%h le=%b rw=%0d, required 00000880 1 11",
               pending_mask, rf_le, rf_rw);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL age_drain: got %0d outstanding busy=%b, required 0 0", exp_q.size(), busy);
    end
    to_edge();
  endtask

  task automatic test_backpressure();
    bit aa[5];
    bit ba[5];
    do_reset();
    exp_q.push_back('{rw: 5'd20, data: 32'hF000_0000});
    exp_q.push_back('{rw: 5'd12, data: 32'hF000_0001});
    exp_q.push_back('{rw: 5'd12, data: 32'hF000_0002});
    exp_q.push_back('{rw: 5'd12, data: 32'hF000_0003});
    exp_q.push_back('{rw: 5'd12, data: 32'hF000_0004});
    exp_q.push_back('{rw: 5'd12, data: 32'hF000_0005});
    step(1'b1, 5'd20, 32'hF000_0000, 1'b1, 5'd12, 32'hF000_0001, aa[0], ba[0]);
    step(1'b1, 5'd12, 32'hF000_0002, 1'b1, 5'd12, 32'hF000_0003, aa[1], ba[1]);
    step(1'b1, 5'd12, 32'hF000_0004, 1'b0, 5'd0,  32'h0,         aa[2], ba[2]);
    checks++;
    if ({aa[0], ba[0], aa[1], ba[1], aa[2]} !== 5'b11111) begin
      errors++;
      $display("FAIL bp_first: got %b, required 11111", {aa[0], ba[0], aa[1], ba[1], aa[2]});
    end
    step(1'b1, 5'd12, 32'hF000_0005, 1'b0, 5'd0, 32'h0, aa[3], ba[3]);
    checks++;
    if (aa[3] !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got accept=%b with A holding 2, required 0", aa[3]);
    end
    step(1'b1, 5'd12, 32'hF000_0005, 1'b0, 5'd0, 32'h0, aa[4], ba[4]);
    checks++;
    if (aa[4] !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_pop: got accept=%b, required 1", aa[4]);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got %0d outstanding busy=%b, required 0 0", exp_q.size(), busy);
    end
    to_edge();
  endtask

  task automatic test_reg_zero();
    bit aa1, ba1, aa2, ba2;
    do_reset();
    exp_q.push_back('{rw: 5'd5, data: 32'h0BAD_F00D});
    step(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'h0, aa1, ba1);
    @(negedge clk);
    checks++;
    if (pending_mask !== 32'h0 || busy !== 1'b1 || aa1 !== 1'b1) begin
      errors++;
      $display("FAIL r0_queued: got mask=%h busy=%b acc=%b, required 0 1 1",
               pending_mask, busy, aa1);
    end
    to_edge();
    step(1'b1, 5'd5, 32'h0BAD_F00D, 1'b0, 5'd0, 32'h0, aa2, ba2);
    @(negedge clk);
    checks++;
    if (rf_le !== 1'b0 || pending_mask !== 32'h20) begin
      errors++;
      $display("FAIL r0_dropped: got le=%b mask=%h, required 0 00000020", rf_le, pending_mask);
    end
    to_edge();
    @(negedge clk);
    checks++;
    if (rf_le !== 1'b1 || rf_rw !== 5'd5) begin
      errors++;
      $display("FAIL r0_next: got le=%b rw=%0d, required 1 5", rf_le, rf_rw);
    end
    to_edge();
  endtask

  task automatic test_mid_reset();
    bit aa1, ba1, aa2, ba2;
    int le_seen;
    do_reset();
    step(1'b1, 5'd0, 32'hC000_0000, 1'b1, 5'd2, 32'hC000_0002, aa1, ba1);
    step(1'b1, 5'd3, 32'hC000_0003, 1'b1, 5'd4, 32'hC000_0004, aa2, ba2);
    @(negedge clk);
    checks++;
    if (pending_mask !== 32'h1C || rf_le !== 1'b0 || {aa1, ba1, aa2, ba2} !== 4'b1111) begin
      errors++;
      $display("FAIL mid_queued: got mask=%h le=%b acc=%b, required 0000001c 0 1111",
               pending_mask, rf_le, {aa1, ba1, aa2, ba2});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pending_mask !== 32'h0 || busy !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got mask=%h busy=%b ready=%b%b, required 0 0 00",
               pending_mask, busy, a_ready, b_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    le_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rf_le === 1'b1) le_seen++;
    end
    checks++;
    if (le_seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_dropped: got %0d write pulses busy=%b, required 0 0", le_seen, busy);
    end
    to_edge();
  endtask

  initial begin
    a_valid = 1'b0; b_valid = 1'b0;
    a_rw = '0; b_rw = '0; a_data = '0; b_data = '0;
    rst_n = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_age_override();
    test_backpressure();
    test_reg_zero();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d writes never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (PW/RW/LE) between two writeback requesters: A (ALU result) and B (memory load result).
- Each requester gets a small FIFO with a valid/ready handshake.
- A round-robin arbiter drains one entry per cycle, with an age override so writes to the same register retire in program order.
- Publishes a pending-write mask that the hazard logic uses to stall dependent reads.

Parameters:
- DATA_W, 32, write data width (matches PW).
- ADDR_W, 5, register address width (matches RW).
- FIFO_DEPTH, 2, entries per requester FIFO (power of 2, 2..4).
- SEQ_W, 3, age-tag width; must satisfy 2^SEQ_W > 2*FIFO_DEPTH+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A offers a write.
- a_ready  out  1  A FIFO can accept.
- a_rw  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid, b_ready, b_rw, b_data: same as A, for requester B.
- rf_pw  out  DATA_W  to register file PW.
- rf_rw  out  ADDR_W  to register file RW.
- rf_le  out  1  to register file LE (one-cycle pulse per write).
- pending_mask  out  32  bit r=1 iff a write to r is queued or on rf_* this cycle.
- busy  out  1  any FIFO non-empty or rf_le=1.

Behaviour:
- Reset (async, rst_n=0):
  - FIFOs emptied and pointers zeroed.
  - Sequence counter = 0; rr_last = B, so A wins the first tie.
  - rf_pw = 0, rf_rw = 0, rf_le = 0, pending_mask = 0, busy = 0.
  - a_ready = b_ready = 0 while rst_n=0; both = 1 on the first cycle after release.
  - Reset mid-operation discards all queued writes; none reach the register file.
- Accept: x_valid & x_ready at a rising edge pushes {rw, data, tag}.
  - tag = seq counter; counter increments by the number of pushes that edge.
  - Simultaneous A and B pushes: A gets tag seq, B gets seq+1 (A is older).
- x_ready is registered and depends only on FIFO count (ready = count < FIFO_DEPTH).
  - A full FIFO is not ready even if it pops in the same cycle; no valid->ready combinational path.
- Arbitration, evaluated every cycle on the FIFO heads:
  - Neither head non-empty: no grant.
  - One head non-empty: grant it.
  - Both heads non-empty, same rw, rw != 0: grant the older tag. Older means (tag_other - tag_this) mod 2^SEQ_W lies in 1..2*FIFO_DEPTH.
  - Otherwise: round-robin; grant the requester other than rr_last.
  - rr_last updates on every grant.
- Output stage: the granted head pops at edge k. rf_pw/rf_rw are loaded at edge k, and rf_le=1 for the cycle following edge k. The register file captures at edge k+1.
  - rf_le returns to 0 the next cycle unless another grant occurs; back-to-back grants give continuous rf_le=1.
- Latency: push at edge k, with the FIFO empty and uncontested, gives a pop/output load at edge k+1, rf_le high in cycle k+1..k+2, and register written at edge k+2.
- Register 0: entries with rw=0 are accepted and arbitrated normally. The output stage forces rf_le=0 for them (write dropped, slot consumed), and they never set pending_mask.
- rf_pw/rf_rw hold their last value when rf_le=0.
- pending_mask is combinational OR over all valid FIFO entries plus the output stage (when rf_le=1). Bit 0 is always 0.

Optional Feature:
- Macro: REGFILE_WB_PERF_EN.
- Defined: adds output perf_conflicts [15:0], reset to 0. It increments (saturating at 16'hFFFF) on each cycle where both FIFO heads are non-empty.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared include regfile_defs.vh holds DATA_W/ADDR_W defaults, the REG_ZERO constant, and the entry field layout (rw, data, tag bit offsets).
- Sub-module wb_fifo (parameterised depth/width; push, pop, head, count, full, empty, valid-entry vector for mask building) is instantiated twice.
- Arbiter, age compare and output stage stay in regfile_wb_arbiter.

Test Plan:
- Reset: hold rst_n=0 with a_valid=1 -> a_ready=b_ready=0, rf_le=0, pending_mask=0. Release -> ready=1 the next cycle, no spurious write.
- Single write: A pushes rw=5, data=32'hDEADBEEF at edge k.
  - pending_mask[5]=1 from k to k+2.
  - rf_le=1 with rf_rw=5, rf_pw=DEADBEEF in cycle k+1.
  - busy drops after k+2.
- Round-robin: A and B each push 2 writes (A:r1,r2; B:r3,r4), all pushed by edge k.
  - Output order is r1, r3, r2, r4 on consecutive cycles starting at edge k+1; rf_le continuous for 4 cycles.
- Age override: B pushes r7=1; the next cycle A pushes r7=2 while B is still queued (force B older via backpressure).
  - B's r7=1 is written first, then A's r7=2; the final write sequence is 1 then 2.
- Full/backpressure: hold a_valid with 3 writes while B is continuously busy.
  - a_ready=0 after 2 accepted; the third is accepted only after a pop.
  - Never more than FIFO_DEPTH entries held.
- r0 and mid-run reset: push rw=0 -> a slot is consumed, rf_le stays 0, pending_mask[0]=0. Assert rst_n with 3 writes queued -> all dropped, no rf_le pulse.
